// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// seg7_scan_ctrl
//
// Multiplexed 7-segment display controller. A binary value captured on a
// load strobe is converted to BCD one bit per cycle (shift-add-3). The last
// completed result is scanned across DIGITS common-anode digits, one digit
// every SCAN_DIV cycles. Values that do not fit in DIGITS decimal digits
// raise ovf and show dashes on every digit.
//
// Parameters:
//   DIGITS   - number of scanned digits (1..8)
//   WIDTH    - binary input width (4..32)
//   SCAN_DIV - clock cycles each digit stays enabled (>= 2)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   value  in   [WIDTH-1:0] unsigned value to display
//   load   in   capture strobe, accepted only while busy = 0
//   busy   out  conversion in progress
//   ovf    out  value exceeds 10^DIGITS-1 (held until the next result)
//   an     out  [DIGITS-1:0] digit enables, active-low
//   seg    out  [6:0] segments, active-low, bit0 = a .. bit6 = g
//
// Build option:
//   SEG7_LZB_EN - when defined, leading zeros above digit 0 are blanked
//                 (digit disabled, segments off). Not applied during ovf.
// ============================================================================
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned SCAN_DIV = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Converter states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_acc;

    // Display state (last completed result)
    logic [BCD_W-1:0] r_disp;
    logic             r_ovf;

    // Scan state
    logic [PRE_W-1:0]  r_pre;
    logic [DIG_W-1:0]  r_dig;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;

    // Combinational helpers
    logic [BCD_W-1:0]  w_adj;
    logic [3:0]        w_nib;
    logic              w_blank_sel;
    logic [DIGITS-1:0] w_blank;
    logic [DIGITS-1:0] w_an_next;
    logic [6:0]        w_seg_next;

    // ------------------------------------------------------------------
    // Segment decode, active-low gfedcba. Codes above 9 cannot come out
    // of the converter; they decode to blank.
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Add-3 correction: every nibble >= 5 gets +3 before the shift so the
    // doubled nibble carries correctly into the next decimal digit.
    // ------------------------------------------------------------------
    always_comb begin
        w_adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            else
                w_adj[4*i +: 4] = r_bcd[4*i +: 4];
        end
    end

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_disp    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_bin     <= value;
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd     <= {w_adj[BCD_W-2:0], r_bin[WIDTH-1]};
                    r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
                    // A 1 leaving the top nibble means the value no longer
                    // fits in DIGITS decimal digits; keep it sticky.
                    r_ovf_acc <= r_ovf_acc | w_adj[BCD_W-1];
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_disp  <= r_bcd;
                    r_ovf   <= r_ovf_acc;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan timing: prescaler and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_dig <= '0;
        end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            if (r_dig == DIG_W'(DIGITS - 1))
                r_dig <= '0;
            else
                r_dig <= r_dig + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking: walk from the top digit down, keeping a
    // running "everything above and including here is zero" flag.
    // ------------------------------------------------------------------
`ifdef SEG7_LZB_EN
    logic w_run;

    always_comb begin
        w_blank = '0;
        w_run   = 1'b1;
        for (int unsigned j = 0; j + 1 < DIGITS; j++) begin
            w_run = w_run & (r_disp[4*(DIGITS-1-j) +: 4] == 4'd0);
            w_blank[DIGITS-1-j] = w_run;
        end
    end
`else
    assign w_blank = '0;
`endif

    // ------------------------------------------------------------------
    // Current digit selection
    // ------------------------------------------------------------------
    always_comb begin
        w_nib       = '0;
        w_blank_sel = 1'b0;
        w_an_next   = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_dig == DIG_W'(i)) begin
                w_nib        = r_disp[4*i +: 4];
                w_blank_sel  = w_blank[i];
                w_an_next[i] = 1'b0;
            end
        end

        w_seg_next = f_decode(w_nib);
        if (r_ovf) begin
            // Overflow: every digit on, all showing a dash.
            w_an_next  = '0;
            w_seg_next = SEG_DASH;
        end else if (w_blank_sel) begin
            w_an_next  = '1;
            w_seg_next = SEG_BLANK;
        end
    end

    // an and seg share one register stage so they can never skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign ovf  = r_ovf;
    assign an   = r_an;
    assign seg  = r_seg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// tb_seg7_scan_ctrl
//
// Drives two controllers (DIGITS=5 and DIGITS=4, WIDTH=16, SCAN_DIV=4) from
// the same stimulus. Each accepted load pushes the value on a scoreboard
// queue; when the conversion finishes the value is popped and one full scan
// of both displays is compared against a decimal reference model.
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned SCAN_DIV = 4;

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] value;

    logic       busy5, ovf5;
    logic [4:0] an5;
    logic [6:0] seg5;
    logic       busy4, ovf4;
    logic [3:0] an4;
    logic [6:0] seg4;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIGITS(5), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) u_dut5 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy5), .ovf(ovf5), .an(an5), .seg(seg5)
    );

    seg7_scan_ctrl #(.DIGITS(4), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) u_dut4 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy4), .ovf(ovf4), .an(an4), .seg(seg4)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned sb_q[$];

    // Rising edges since reset was last seen
    int unsigned cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Length of the most recent busy pulse of each instance
    int unsigned run5 = 0, run4 = 0, len5 = 0, len4 = 0;
    always @(negedge clk) begin
        if (busy5 === 1'b1) run5 <= run5 + 1;
        else if (run5 != 0) begin len5 <= run5; run5 <= 0; end
        if (busy4 === 1'b1) run4 <= run4 + 1;
        else if (run4 != 0) begin len4 <= run4; run4 <= 0; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] dec7(input int unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int unsigned p10(input int unsigned n);
        int unsigned r = 1;
        for (int unsigned k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    // Expected {an[7:0], seg[6:0]} for digit slot idx of a D-digit display
    function automatic logic [14:0] model(input int unsigned v, input int unsigned D,
                                         input int unsigned idx);
        logic [7:0] a;
        logic [6:0] s;
        if (v > p10(D) - 1) begin
            a = 8'h00;
            s = 7'b0111111;
        end else if (LZB && idx > 0 && v < p10(idx)) begin
            a = 8'hFF;
            s = 7'b1111111;
        end else begin
            a = 8'hFF;
            a[idx] = 1'b0;
            s = dec7((v / p10(idx)) % 10);
        end
        return {a, s};
    endfunction

    task automatic pulse_load(input int unsigned v, input bit accept);
        value = v[WIDTH-1:0];
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        if (accept) sb_q.push_back(v);
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        while (busy5 !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(n >= 200), 0);
        @(negedge clk);
        check("busy_len5", len5, WIDTH + 1);
        check("busy_len4", len4, WIDTH + 1);
    endtask

    task automatic check_scan();
        int unsigned v;
        logic [14:0] e5, e4;
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() == 0) return;
        v = sb_q.pop_front();
        check($sformatf("ovf5 v=%0d", v), 32'(ovf5), 32'(v > 99999));
        check($sformatf("ovf4 v=%0d", v), 32'(ovf4), 32'(v > 9999));
        for (int i = 0; i < 5 * SCAN_DIV; i++) begin
            e5 = model(v, 5, ((cyc - 1) / SCAN_DIV) % 5);
            e4 = model(v, 4, ((cyc - 1) / SCAN_DIV) % 4);
            check($sformatf("an5 v=%0d k=%0d", v, cyc),  32'(an5),  32'(e5[11:7]));
            check($sformatf("seg5 v=%0d k=%0d", v, cyc), 32'(seg5), 32'(e5[6:0]));
            check($sformatf("an4 v=%0d k=%0d", v, cyc),  32'(an4),  32'(e4[10:7]));
            check($sformatf("seg4 v=%0d k=%0d", v, cyc), 32'(seg4), 32'(e4[6:0]));
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        check("rst_an5",   32'(an5),   32'h1F);
        check("rst_seg5",  32'(seg5),  32'h7F);
        check("rst_busy5", 32'(busy5), 0);
        check("rst_ovf5",  32'(ovf5),  0);
        check("rst_an4",   32'(an4),   32'hF);
        check("rst_busy4", 32'(busy4), 0);

        rst = 1'b0;
        @(negedge clk);
        check("first_an5",  32'(an5),  32'h1E);
        check("first_seg5", 32'(seg5), 32'h40);
        sb_q.push_back(0);
        check_scan();

        // Main conversions
        pulse_load(12345, 1'b1); wait_done(); check_scan();
        pulse_load(42,    1'b1); wait_done(); check_scan();
        pulse_load(10000, 1'b1); wait_done(); check_scan();
        pulse_load(9999,  1'b1); wait_done(); check_scan();

        // Load while busy is dropped
        pulse_load(500, 1'b1);
        repeat (2) @(negedge clk);
        pulse_load(777, 1'b0);
        wait_done(); check_scan();

        // Load coinciding with the DONE cycle is dropped
        pulse_load(321, 1'b1);
        repeat (16) @(negedge clk);
        pulse_load(999, 1'b0);
        wait_done(); check_scan();

        // Reset on the eighth shift cycle aborts the conversion
        pulse_load(65535, 1'b1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy5", 32'(busy5), 0);
        check("abort_busy4", 32'(busy4), 0);
        check("abort_ovf4",  32'(ovf4),  0);
        check("abort_an5",   32'(an5),   32'h1F);
        sb_q.delete();
        sb_q.push_back(0);
        @(negedge clk);
        check_scan();

        pulse_load(65535, 1'b1); wait_done(); check_scan();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
